// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes BYTES_PER_CYCLE bytes of a 128-bit state per clock
// through shared forward S-boxes, then hands the result downstream on a valid/ready handshake.
module sub_bytes_iter #(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);

   localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
   localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam int CHUNK_W   = 8 * BYTES_PER_CYCLE;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   // Forward S-box, entry 0x00 in the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t                fsm_q, fsm_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic [127:0]        state_q, state_d;
   logic                out_valid_q, out_valid_d;
   logic [CHUNK_W-1:0]  chunk_in;
   logic [CHUNK_W-1:0]  chunk_out;

   always_comb chunk_in = state_q[127 - CHUNK_W * int'(step_q) -: CHUNK_W];

   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
         assign chunk_out[CHUNK_W-1-8*gi -: 8] =
            SBOX_TBL[2047 - 8 * int'(chunk_in[CHUNK_W-1-8*gi -: 8]) -: 8];
      end
   endgenerate

   always_comb begin
      fsm_d       = fsm_q;
      step_d      = step_q;
      state_d     = state_q;
      out_valid_d = out_valid_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_d = data_in;
               step_d  = '0;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d[127 - CHUNK_W * int'(step_q) -: CHUNK_W] = chunk_out;
            if (step_q == LAST_STEP) begin
               fsm_d       = DONE;
               step_d      = '0;
               out_valid_d = 1'b1;
            end else begin
               step_d = step_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d       = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         step_q      <= '0;
         state_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         step_q      <= step_d;
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
      end
   end

   // The state register doubles as the output register: it only changes in IDLE/RUN.
   assign in_ready  = (fsm_q == IDLE);
   assign out_valid = out_valid_q;
   assign data_out  = state_q;
   assign busy      = (fsm_q != IDLE);

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter at BYTES_PER_CYCLE = 4, 1 and 16 side by side.
module tb_sub_bytes_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic [127:0] data_in;
   int           sel;
   int           checks   = 0;
   int           failures = 0;

   logic         in_valid_w  [3];
   logic         out_ready_w [3];
   logic         in_ready_w  [3];
   logic         out_valid_w [3];
   logic         busy_w      [3];
   logic [127:0] data_out_w  [3];

   int    lat_tbl [3] = '{4, 16, 1};
   string nm_tbl  [3] = '{"bpc4", "bpc1", "bpc16"};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_steer
         assign in_valid_w[gi]  = in_valid  && (sel == gi);
         assign out_ready_w[gi] = out_ready && (sel == gi);
      end
   endgenerate

   sub_bytes_iter #(.BYTES_PER_CYCLE(4)) u_bpc4 (
      .clk(clk), .rst(rst), .in_valid(in_valid_w[0]), .in_ready(in_ready_w[0]),
      .data_in(data_in), .out_valid(out_valid_w[0]), .out_ready(out_ready_w[0]),
      .data_out(data_out_w[0]), .busy(busy_w[0]));

   sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_bpc1 (
      .clk(clk), .rst(rst), .in_valid(in_valid_w[1]), .in_ready(in_ready_w[1]),
      .data_in(data_in), .out_valid(out_valid_w[1]), .out_ready(out_ready_w[1]),
      .data_out(data_out_w[1]), .busy(busy_w[1]));

   sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_bpc16 (
      .clk(clk), .rst(rst), .in_valid(in_valid_w[2]), .in_ready(in_ready_w[2]),
      .data_in(data_in), .out_valid(out_valid_w[2]), .out_ready(out_ready_w[2]),
      .data_out(data_out_w[2]), .busy(busy_w[2]));

   localparam logic [127:0] V1_IN  = 128'h0;
   localparam logic [127:0] V1_OUT = 128'h63636363636363636363636363636363;
   localparam logic [127:0] V2_IN  = 128'h000000005d5d5d5d9f9f9f9ff9f9f9f9;
   localparam logic [127:0] V2_OUT = 128'h636363634c4c4c4cdbdbdbdb99999999;
   localparam logic [127:0] V3_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] V3_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] V4_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] V4_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s [%s] got=%h exp=%h", tag, nm_tbl[sel], got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (out_valid_w[sel] !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
   endtask

   // Offer one block, wait for out_valid and check latency and result; caller handles release.
   task automatic run_block(input logic [127:0] din, input logic [127:0] exp, input string tag);
      int n;
      check({tag, "_in_ready"}, 128'(in_ready_w[sel]), 128'd1);
      data_in  = din;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check({tag, "_busy"}, 128'(busy_w[sel]), 128'd1);
      wait_out(n);
      check({tag, "_latency"}, 128'(n), 128'(lat_tbl[sel]));
      check({tag, "_data"}, data_out_w[sel], exp);
      $display("block %s [%s] in=%h out=%h latency=%0d", tag, nm_tbl[sel], din, data_out_w[sel], n);
   endtask

   task automatic release_block(input string tag);
      out_ready = 1'b1;
      tick();
      check({tag, "_rel_valid"}, 128'(out_valid_w[sel]), 128'd0);
      check({tag, "_rel_ready"}, 128'(in_ready_w[sel]), 128'd1);
   endtask

   initial begin
      int n;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; sel = 0;
      repeat (2) tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sel = k;
         check("rst_out_valid", 128'(out_valid_w[k]), 128'd0);
         check("rst_data_out", data_out_w[k], 128'd0);
         check("rst_in_ready", 128'(in_ready_w[k]), 128'd1);
         check("rst_busy", 128'(busy_w[k]), 128'd0);
      end

      for (int k = 0; k < 3; k++) begin
         sel = k;
         out_ready = 1'b1;
         run_block(V1_IN, V1_OUT, "zero");
         release_block("zero");
         run_block(V2_IN, V2_OUT, "shiftrows_vec");
         release_block("shiftrows_vec");
         run_block(V4_IN, V4_OUT, "sbox_col0");
         release_block("sbox_col0");

         // Backpressure: output must hold for 10 cycles with in_ready low.
         out_ready = 1'b0;
         run_block(V3_IN, V3_OUT, "fips_r1");
         for (int c = 0; c < 10; c++) begin
            tick();
            check("hold_data", data_out_w[k], V3_OUT);
            check("hold_valid", 128'(out_valid_w[k]), 128'd1);
            check("hold_in_ready", 128'(in_ready_w[k]), 128'd0);
         end
         release_block("fips_r1");

         // in_valid held high with new data while busy must be ignored.
         out_ready = 1'b0;
         data_in   = V1_IN;
         in_valid  = 1'b1;
         tick();
         data_in = V2_IN;
         repeat (lat_tbl[k] + 2) tick();
         check("ign_valid", 128'(out_valid_w[k]), 128'd1);
         check("ign_data", data_out_w[k], V1_OUT);
         check("ign_in_ready", 128'(in_ready_w[k]), 128'd0);
         release_block("ign_first");
         tick();
         in_valid = 1'b0;
         wait_out(n);
         check("ign_second_latency", 128'(n), 128'(lat_tbl[k]));
         check("ign_second_data", data_out_w[k], V2_OUT);
         $display("block ign_second [%s] out=%h latency=%0d", nm_tbl[k], data_out_w[k], n);
         release_block("ign_second");
      end

      // Reset in the middle of RUN discards the partial block.
      sel       = 0;
      out_ready = 1'b1;
      data_in   = V3_IN;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("midrun_busy", 128'(busy_w[0]), 128'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrun_rst_valid", 128'(out_valid_w[0]), 128'd0);
      check("midrun_rst_data", data_out_w[0], 128'd0);
      check("midrun_rst_busy", 128'(busy_w[0]), 128'd0);
      check("midrun_rst_ready", 128'(in_ready_w[0]), 128'd1);
      run_block(V3_IN, V3_OUT, "after_rst");
      release_block("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
